// File: rtl/pattern_merge_pkg.sv
// Shared types and constants for the pattern-merge pipeline: merge modes, MISR taps and
// signature width.
package pattern_merge_pkg;

    localparam int unsigned SIG_W = 16;

    // Feedback taps at bits 15, 13, 12 and 10 of the signature register.
    localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        PM_NOR  = 2'd0,
        PM_NAND = 2'd1,
        PM_PASS = 2'd2,
        PM_XMRG = 2'd3
    } pm_mode_e;

endpackage

// File: rtl/pattern_merge_pipe_stage.sv
// pm_stage: one elastic register slice holding a valid bit and a data word.
// Loads whenever the slice is allowed to advance.
module pm_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (adv) begin
            valid_q <= load_valid;
            // Bubbles leave the data word untouched.
            if (load_valid) begin
                data_q <= load_data;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pattern_merge_pipe.sv
// Selectable NAND/NOR/XOR merge across lanes, carried through a DEPTH-stage elastic
// valid/ready pipeline, with a MISR signature and saturating beat counter on the output.
module pattern_merge_pipe
    import pattern_merge_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                         blif_clk_net,
    input  logic                         blif_reset_net,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [1:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    input  logic                         sig_clear,
    output logic [SIG_W-1:0]             sig,
    output logic [SIG_W-1:0]             beat_cnt
);

    localparam int unsigned DW     = CHANNELS * WIDTH;
    localparam int unsigned NCHUNK = (DW + SIG_W - 1) / SIG_W;

    pm_mode_e      mode;
    logic [DW-1:0] merged;

    assign mode = pm_mode_e'(in_mode);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] rot;
        logic [WIDTH-1:0] nbr;
        logic [WIDTH-1:0] y;

        assign a   = in_data[c*WIDTH +: WIDTH];
        assign rot = {a[WIDTH-2:0], a[WIDTH-1]};
        assign nbr = in_data[((c + 1) % CHANNELS)*WIDTH +: WIDTH];

        always_comb begin
            y = a;
            case (mode)
                PM_NOR:  y = ~(a | rot);
                PM_NAND: y = ~(a & rot);
                PM_PASS: y = a;
                PM_XMRG: y = a ^ nbr;
                default: y = a;
            endcase
        end

        assign merged[c*WIDTH +: WIDTH] = y;
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DW-1:0]    d [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          ld_valid;
        logic [DW-1:0] ld_data;

        // A stage advances when empty or when its successor advances.
        if (k == DEPTH - 1) begin : g_last
            assign adv[k] = ~v[k] | out_ready;
        end else begin : g_mid
            assign adv[k] = ~v[k] | adv[k+1];
        end

        if (k == 0) begin : g_first
            assign ld_valid = in_valid;
            assign ld_data  = merged;
        end else begin : g_rest
            assign ld_valid = v[k-1];
            assign ld_data  = d[k-1];
        end

        pm_stage #(
            .DW(DW)
        ) u_stage (
            .clk        (blif_clk_net),
            .rst_n      (blif_reset_net),
            .adv        (adv[k]),
            .load_valid (ld_valid),
            .load_data  (ld_data),
            .valid      (v[k]),
            .data       (d[k])
        );
    end

    assign in_ready  = adv[0] & blif_reset_net;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    logic                    out_hs;
    logic [NCHUNK*SIG_W-1:0] padded;
    logic [SIG_W-1:0]        fold;
    logic                    feedback;
    logic [SIG_W-1:0]        sig_d, sig_q;
    logic [SIG_W-1:0]        cnt_d, cnt_q;

    assign out_hs   = out_valid & out_ready;
    assign feedback = ^(sig_q & MISR_TAPS);

    always_comb begin
        padded         = '0;
        padded[DW-1:0] = out_data;
        fold           = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            fold = fold ^ padded[i*SIG_W +: SIG_W];
        end
    end

    // Clear takes priority over a coincident output handshake.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (sig_clear) begin
            sig_d = '0;
            cnt_d = '0;
        end else if (out_hs) begin
            sig_d = {sig_q[SIG_W-2:0], feedback} ^ fold;
            cnt_d = (cnt_q == {SIG_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            sig_q <= '0;
            cnt_q <= '0;
        end else begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

    assign sig      = sig_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Self-checking bench for pattern_merge_pipe (WIDTH=4, CHANNELS=2, DEPTH=2): a negedge
// monitor scores every output beat against a queue filled on input handshakes.
module tb_pattern_merge_pipe;

    localparam int W  = 4;
    localparam int CH = 2;
    localparam int DP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        sig_clear;
    logic [15:0] sig;
    logic [15:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q[$];
    logic [15:0] m_sig = 16'h0;
    logic [15:0] m_cnt = 16'h0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h0;
    logic        saw_stall_ready = 1'b0;

    always #5 clk = ~clk;

    pattern_merge_pipe #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .DEPTH    (DP)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_mode        (in_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .sig_clear      (sig_clear),
        .sig            (sig),
        .beat_cnt       (beat_cnt)
    );

    function automatic logic [7:0] model(input logic [7:0] din, input logic [1:0] m);
        logic [7:0] res;
        logic [3:0] a, r, b;
        res = 8'h0;
        for (int c = 0; c < CH; c++) begin
            a = din[c*W +: W];
            r = {a[2], a[1], a[0], a[3]};
            b = din[((c + 1) % CH)*W +: W];
            case (m)
                2'd0: res[c*W +: W] = ~(a | r);
                2'd1: res[c*W +: W] = ~(a & r);
                2'd2: res[c*W +: W] = a;
                default: res[c*W +: W] = a ^ b;
            endcase
        end
        return res;
    endfunction

    // Scoreboard monitor: observes the state settled after the last posedge and the
    // handshakes that will complete on the next one.
    always @(negedge clk) begin
        logic       exp_rdy;
        logic [7:0] exp;
        logic       fb;
        if (!rst_n) begin
            q.delete();
            m_sig = 16'h0;
            m_cnt = 16'h0;
            prev_stall = 1'b0;
        end else begin
            checks += 2;
            if (sig !== m_sig) begin
                errors++;
                $display("FAIL sig: got %h expected %h at %0t", sig, m_sig, $time);
            end
            if (beat_cnt !== m_cnt) begin
                errors++;
                $display("FAIL beat_cnt: got %0d expected %0d at %0t", beat_cnt, m_cnt, $time);
            end
            exp_rdy = !(q.size() == DP && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b occ=%0d at %0t",
                         in_ready, exp_rdy, q.size(), $time);
            end
            if (!in_ready) saw_stall_ready = 1'b1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: got v=%b d=%h expected v=1 d=%h at %0t",
                             out_valid, out_data, prev_data, $time);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_beat: got %h expected none at %0t", out_data, $time);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL out_data: got %h expected %h at %0t",
                                 out_data, exp, $time);
                    end
                end
                fb = m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10];
                m_sig = {m_sig[14:0], fb} ^ {8'h00, out_data};
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
            end
            if (sig_clear) begin
                m_sig = 16'h0;
                m_cnt = 16'h0;
            end
            if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic send(input logic [7:0] dat, input logic [1:0] m);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = dat;
        in_mode  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for data %h", dat);
        end
    endtask

    task automatic drain(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_out_valid: got %b expected 0", out_valid);
        end
        if (sig !== 16'h0) begin
            errors++;
            $display("FAIL idle_sig: got %h expected 0000", sig);
        end
        if (beat_cnt !== 16'h0) begin
            errors++;
            $display("FAIL idle_cnt: got %0d expected 0", beat_cnt);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_nor();
        out_ready = 1'b1;
        send(8'h81, 2'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nor_latency_early: got out_valid=%b expected 0", out_valid);
        end
        @(posedge clk);
        #2;
        checks += 2;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL nor_latency: got out_valid=%b expected 1", out_valid);
        end
        if (out_data !== 8'h6C) begin
            errors++;
            $display("FAIL nor_data: got %h expected 6c", out_data);
        end
        @(posedge clk);
        #2;
        checks += 2;
        if (sig !== 16'h006C) begin
            errors++;
            $display("FAIL nor_sig: got %h expected 006c", sig);
        end
        if (beat_cnt !== 16'd1) begin
            errors++;
            $display("FAIL nor_cnt: got %0d expected 1", beat_cnt);
        end
    endtask

    task automatic test_modes();
        logic [15:0] base;
        logic ok;
        base = beat_cnt;
        out_ready = 1'b1;
        send(8'h3A, 2'd3);
        send(8'hFF, 2'd1);
        send(8'h5A, 2'd2);
        drain(ok);
        checks += 2;
        if (!ok) begin
            errors++;
            $display("FAIL modes_drain: got %0d pending expected 0", q.size());
        end
        if (beat_cnt !== base + 16'd3) begin
            errors++;
            $display("FAIL modes_cnt: got %0d expected %0d", beat_cnt, base + 16'd3);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        sig_clear = 1'b1;
        @(posedge clk);
        #2;
        sig_clear = 1'b0;
        saw_stall_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(8'h13 * (i + 1)), 2'(i % 4));
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready = (i % 3 == 0);
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        drain(ok);
        checks += 3;
        if (!ok) begin
            errors++;
            $display("FAIL stream_drain: got %0d pending expected 0", q.size());
        end
        if (beat_cnt !== 16'd8) begin
            errors++;
            $display("FAIL stream_cnt: got %0d expected 8", beat_cnt);
        end
        if (saw_stall_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_backpressure: got in_ready never low expected a stall");
        end
    endtask

    task automatic test_clear();
        logic ok;
        logic seen;
        out_ready = 1'b1;
        send(8'h3A, 2'd3);
        drain(ok);
        send(8'h5A, 2'd2);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clear_wait: got out_valid=0 expected 1");
        end
        sig_clear = 1'b1;
        @(posedge clk);
        #2;
        sig_clear = 1'b0;
        checks += 2;
        if (sig !== 16'h0) begin
            errors++;
            $display("FAIL clear_sig: got %h expected 0000", sig);
        end
        if (beat_cnt !== 16'h0) begin
            errors++;
            $display("FAIL clear_cnt: got %0d expected 0", beat_cnt);
        end
        send(8'h81, 2'd0);
        drain(ok);
        checks += 2;
        if (sig !== 16'h006C) begin
            errors++;
            $display("FAIL clear_rebuild_sig: got %h expected 006c", sig);
        end
        if (beat_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clear_rebuild_cnt: got %0d expected 1", beat_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'h11, 2'd2);
        send(8'h22, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
        end
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b expected 0", in_ready);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat: got out_valid=1 data %h expected 0", out_data);
            end
        end
        checks += 2;
        if (sig !== 16'h0) begin
            errors++;
            $display("FAIL midreset_sig: got %h expected 0000", sig);
        end
        if (beat_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midreset_cnt: got %0d expected 0", beat_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h0;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        sig_clear = 1'b0;
        test_reset();
        test_nor();
        test_modes();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
